// File: rtl/ctrl_pkg.sv
// Shared phase codes, instruction-class indices and class helpers for the control
// sequencer and the strobe generator.
package ctrl_pkg;

  localparam logic [2:0] PhFetch  = 3'b000;
  localparam logic [2:0] PhDecode = 3'b001;
  localparam logic [2:0] PhRead   = 3'b010;
  localparam logic [2:0] PhAlu    = 3'b011;
  localparam logic [2:0] PhEnd    = 3'b100;

  // Lower index = higher priority when several decoder flags are raised.
  localparam int unsigned ClsW    = 7;
  localparam int unsigned ClsAlu  = 0;
  localparam int unsigned ClsLd   = 1;
  localparam int unsigned ClsSt   = 2;
  localparam int unsigned ClsPush = 3;
  localparam int unsigned ClsPop  = 4;
  localparam int unsigned ClsJump = 5;
  localparam int unsigned ClsBe   = 6;

  typedef enum logic [2:0] {
    StFetch  = PhFetch,
    StDecode = PhDecode,
    StRead   = PhRead,
    StAlu    = PhAlu,
    StEnd    = PhEnd
  } phase_e;

  function automatic logic [ClsW-1:0] cls_onehot(input logic [ClsW-1:0] raw);
    logic [ClsW-1:0] oh;
    oh = '0;
    for (int i = int'(ClsW) - 1; i >= 0; i--) begin
      if (raw[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W.
module retire_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle CPU phase sequencer with sticky halt and retire counting.
// Optional single-step gating of FETCH: define CONTROL_SEQUENCER_SINGLE_STEP_EN.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  input  logic             step_req,
`endif
  input  logic             mem_ready,
  input  logic             hlt,
  input  logic             alu,
  input  logic             ld,
  input  logic             st,
  input  logic             push,
  input  logic             pop,
  input  logic             jump,
  input  logic             be,
  output logic             s2,
  output logic             s1,
  output logic             s0,
  output logic             halted,
  output logic             alu_q,
  output logic             ld_q,
  output logic             st_q,
  output logic             push_q,
  output logic             pop_q,
  output logic             jump_q,
  output logic             be_q,
  output logic             advance,
  output logic [CNT_W-1:0] retired
);

  phase_e          state_q, state_d;
  logic            halted_q, halted_d;
  logic [ClsW-1:0] cls_q, cls_d, cls_raw;
  logic            fetch_go;

  always_comb begin
    cls_raw          = '0;
    cls_raw[ClsAlu]  = alu;
    cls_raw[ClsLd]   = ld;
    cls_raw[ClsSt]   = st;
    cls_raw[ClsPush] = push;
    cls_raw[ClsPop]  = pop;
    cls_raw[ClsJump] = jump;
    cls_raw[ClsBe]   = be;
  end

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  logic pending_q, pending_d, step_prev_q;

  assign fetch_go = mem_ready & pending_q;

  always_comb begin
    pending_d = pending_q;
    if (step_req && !step_prev_q) pending_d = 1'b1;
    // Leaving FETCH consumes the step, even if a new pulse arrives on the same edge.
    if (state_q == StFetch && !halted_q && fetch_go) pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      step_prev_q <= step_req;
    end
  end
`else
  assign fetch_go = mem_ready;
`endif

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    cls_d    = cls_q;
    if (halted_q) begin
      state_d = StFetch;
    end else begin
      case (state_q)
        StFetch:  if (fetch_go) state_d = StDecode;
        StDecode: begin
          if (hlt) begin
            halted_d = 1'b1;
            state_d  = StFetch;
          end else begin
            cls_d   = cls_onehot(cls_raw);
            state_d = (|cls_raw) ? StRead : StEnd;
          end
        end
        StRead: begin
          if (!((cls_q[ClsLd] || cls_q[ClsPop]) && !mem_ready)) begin
            state_d = cls_q[ClsAlu] ? StAlu : StEnd;
          end
        end
        StAlu:   state_d = StEnd;
        StEnd:   state_d = StFetch;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StFetch;
      halted_q <= 1'b0;
      cls_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      cls_q    <= cls_d;
    end
  end

  assign advance    = (state_d != state_q);
  assign {s2, s1, s0} = state_q;
  assign halted     = halted_q;
  assign alu_q      = cls_q[ClsAlu];
  assign ld_q       = cls_q[ClsLd];
  assign st_q       = cls_q[ClsSt];
  assign push_q     = cls_q[ClsPush];
  assign pop_q      = cls_q[ClsPop];
  assign jump_q     = cls_q[ClsJump];
  assign be_q       = cls_q[ClsBe];

  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clk  (clk),
    .rst  (rst),
    .en   ((state_q == StEnd) && !halted_q),
    .count(retired)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed tables, corner sequences and
// randomized instructions checked against a per-instruction phase-list model.
module tb_control_sequencer;

  localparam int unsigned CW = 4;
  localparam logic [2:0] F = 3'd0, D = 3'd1, R = 3'd2, A = 3'd3, E = 3'd4;
  // Class vector as seen by the bench: bit 6 = alu (highest priority) .. bit 0 = be.
  localparam logic [6:0] C0 = 7'h00, CALU = 7'h40, CLD = 7'h20, CST = 7'h10, CPUSH = 7'h08;
  localparam logic [6:0] CPOP = 7'h04, CALL = 7'h7f;
  localparam logic H = 1'b1, L = 1'b0;

  logic clk = 1'b0;
  logic rst, mem_ready, hlt;
  logic [6:0] cls;
  logic s2, s1, s0, halted, advance;
  logic alu_q, ld_q, st_q, push_q, pop_q, jump_q, be_q;
  logic [CW-1:0] retired;
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  logic step_req;
`endif

  control_sequencer #(.CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    .step_req (step_req),
`endif
    .mem_ready(mem_ready),
    .hlt      (hlt),
    .alu      (cls[6]),
    .ld       (cls[5]),
    .st       (cls[4]),
    .push     (cls[3]),
    .pop      (cls[2]),
    .jump     (cls[1]),
    .be       (cls[0]),
    .s2       (s2),
    .s1       (s1),
    .s0       (s0),
    .halted   (halted),
    .alu_q    (alu_q),
    .ld_q     (ld_q),
    .st_q     (st_q),
    .push_q   (push_q),
    .pop_q    (pop_q),
    .jump_q   (jump_q),
    .be_q     (be_q),
    .advance  (advance),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  logic [2:0] phase;
  logic [6:0] qv;
  assign phase = {s2, s1, s0};
  assign qv    = {alu_q, ld_q, st_q, push_q, pop_q, jump_q, be_q};

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic          mr;
    logic          h;
    logic [6:0]    c;
    logic [2:0]    ph;
    logic          adv;
    logic [6:0]    q;
    logic [CW-1:0] ret;
  } vec_t;

  function automatic vec_t row(logic mr, logic h, logic [6:0] c, logic [2:0] ph, logic adv,
                               logic [6:0] q, logic [CW-1:0] ret);
    vec_t v;
    v.mr = mr; v.h = h; v.c = c; v.ph = ph; v.adv = adv; v.q = q; v.ret = ret;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, check before the next rising edge.
  task automatic apply(vec_t v, string tag);
    @(negedge clk);
    mem_ready = v.mr;
    hlt       = v.h;
    cls       = v.c;
    #1;
    check({tag, ".phase"},   32'(phase),   32'(v.ph));
    check({tag, ".advance"}, 32'(advance), 32'(v.adv));
    check({tag, ".class_q"}, 32'(qv),      32'(v.q));
    check({tag, ".retired"}, 32'(retired), 32'(v.ret));
    check({tag, ".halted"},  32'(halted),  32'(0));
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    hlt       = 1'b0;
    cls       = '0;
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    step_req  = 1'b0;
`endif
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("reset.phase",   32'(phase),   32'(F));
    check("reset.halted",  32'(halted),  32'(0));
    check("reset.class_q", 32'(qv),      32'(0));
    check("reset.retired", 32'(retired), 32'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t t_alu[6];
  vec_t t_ld[9];
  vec_t t_nop[8];
  vec_t q[$];

  // Reference: expand one instruction into its expected per-cycle phase list.
  task automatic run_instr(int fw, int rw, logic [6:0] c, inout logic [6:0] eq,
                           inout logic [CW-1:0] er);
    logic [6:0] oh;
    oh = '0;
    for (int b = 6; b >= 0; b--) begin
      if (c[b]) begin
        oh = 7'(1 << b);
        break;
      end
    end
    q = {};
    for (int i = 0; i < fw; i++) q.push_back(row(L, 1'($urandom), 7'($urandom), F, L, eq, er));
    q.push_back(row(H, 1'($urandom), 7'($urandom), F, H, eq, er));
    q.push_back(row(1'($urandom), L, c, D, H, eq, er));
    if (c != 0) begin
      if (oh == CLD || oh == CPOP) begin
        for (int i = 0; i < rw; i++) q.push_back(row(L, 1'($urandom), 7'($urandom), R, L, oh, er));
        q.push_back(row(H, 1'($urandom), 7'($urandom), R, H, oh, er));
      end else begin
        q.push_back(row(1'($urandom), 1'($urandom), 7'($urandom), R, H, oh, er));
      end
      if (oh == CALU) q.push_back(row(1'($urandom), 1'($urandom), 7'($urandom), A, H, oh, er));
    end
    q.push_back(row(1'($urandom), 1'($urandom), 7'($urandom), E, H, oh, er));
    foreach (q[i]) apply(q[i], "rand");
    eq = oh;
    er = er + CW'(1);
  endtask

  initial begin
    logic [6:0]    eq;
    logic [CW-1:0] er;
    logic [6:0]    c;

    t_alu = '{row(H, L, C0,   F, H, C0, 4'd0), row(H, L, CALU, D, H, C0, 4'd0),
              row(H, H, CALL, R, H, CALU, 4'd0), row(H, H, CALL, A, H, CALU, 4'd0),
              row(H, H, CALL, E, H, CALU, 4'd0), row(L, H, CALL, F, L, CALU, 4'd1)};
    t_ld  = '{row(H, L, C0, F, H, C0, 4'd0), row(H, L, CLD, D, H, C0, 4'd0),
              row(L, L, C0, R, L, CLD, 4'd0), row(L, L, C0, R, L, CLD, 4'd0),
              row(L, L, C0, R, L, CLD, 4'd0), row(H, L, C0, R, H, CLD, 4'd0),
              row(L, L, C0, E, H, CLD, 4'd0), row(L, L, C0, F, L, CLD, 4'd1),
              row(L, L, C0, F, L, CLD, 4'd1)};
    t_nop = '{row(H, L, C0, F, H, C0, 4'd0), row(H, L, C0, D, H, C0, 4'd0),
              row(L, L, CALL, E, H, C0, 4'd0), row(H, L, C0, F, H, C0, 4'd1),
              row(H, L, CST | CPUSH, D, H, C0, 4'd1), row(L, L, C0, R, H, CST, 4'd1),
              row(L, L, C0, E, H, CST, 4'd1), row(L, L, C0, F, L, CST, 4'd2)};

    do_reset();
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    mem_ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("step.idle_phase",   32'(phase),   32'(F));
    check("step.idle_retired", 32'(retired), 32'(0));
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("step.one_pulse_retired", 32'(retired), 32'(1));
    check("step.one_pulse_phase",   32'(phase),   32'(F));
    mem_ready = 1'b0;
    repeat (2) begin
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      @(negedge clk);
    end
    mem_ready = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("step.double_pulse_retired", 32'(retired), 32'(2));
`else
    foreach (t_alu[i]) apply(t_alu[i], "alu");
    do_reset();
    foreach (t_ld[i]) apply(t_ld[i], "ld_wait");
    do_reset();
    foreach (t_nop[i]) apply(t_nop[i], "nop_st_push");

    // Reset asserted between clock edges while a load is stalled in READ.
    apply(row(H, L, C0, F, H, CST, 4'd2), "pre_rst");
    apply(row(H, L, CLD, D, H, CST, 4'd2), "pre_rst");
    apply(row(L, L, C0, R, L, CLD, 4'd2), "pre_rst");
    #2 rst = 1'b1;
    #1;
    check("rst_read.phase",   32'(phase),   32'(F));
    check("rst_read.halted",  32'(halted),  32'(0));
    check("rst_read.retired", 32'(retired), 32'(0));
    check("rst_read.class_q", 32'(qv),      32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Halt together with alu: class keeps the earlier st, everything freezes.
    do_reset();
    apply(row(H, L, C0, F, H, C0, 4'd0), "halt_pre");
    apply(row(H, L, CST, D, H, C0, 4'd0), "halt_pre");
    apply(row(H, L, C0, R, H, CST, 4'd0), "halt_pre");
    apply(row(H, L, C0, E, H, CST, 4'd0), "halt_pre");
    apply(row(H, L, C0, F, H, CST, 4'd1), "halt_pre");
    apply(row(H, H, CALU, D, H, CST, 4'd1), "halt_decode");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      hlt       = 1'($urandom);
      cls       = 7'($urandom);
      #1;
      check("halt.phase",   32'(phase),   32'(F));
      check("halt.halted",  32'(halted),  32'(1));
      check("halt.advance", 32'(advance), 32'(0));
      check("halt.retired", 32'(retired), 32'(1));
      check("halt.class_q", 32'(qv),      32'(CST));
    end

    // Counter wrap with CNT_W = 4: 16 back-to-back NOPs.
    do_reset();
    mem_ready = 1'b1;
    repeat (45) @(negedge clk);
    #1;
    check("wrap.retired_15", 32'(retired), 32'(15));
    repeat (3) @(negedge clk);
    #1;
    check("wrap.retired_0", 32'(retired), 32'(0));

    do_reset();
    eq = '0;
    er = '0;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       c = '0;
        1:       c = 7'(1 << $urandom_range(0, 6));
        default: c = 7'($urandom & $urandom);
      endcase
      run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), c, eq, er);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
